// File: rtl/flex_enable_gen_if.sv
// Channel bus of flex_enable_gen: per-channel strobes and clears in;
// pulses, status flags and the selected event count out.
interface flex_enable_gen_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 8
);
   localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] slow_enable;
   logic [NUM_CH-1:0] ovr_clr;
   logic [SEL_W-1:0]  cnt_sel;
   logic [NUM_CH-1:0] fast_enable;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] overrun;
   logic [CNT_W-1:0]  cnt_out;

   modport master (
      output slow_enable, ovr_clr, cnt_sel,
      input  fast_enable, busy, overrun, cnt_out
   );

   modport slave (
      input  slow_enable, ovr_clr, cnt_sel,
      output fast_enable, busy, overrun, cnt_out
   );
endinterface

// File: rtl/flex_enable_gen.sv
// Per-channel edge-triggered fixed-width enable pulse generator with sticky overrun flags.
// Define FLEX_ENABLE_CNT_EN to add saturating per-channel accepted-trigger counters.
module flex_enable_gen #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned PULSE_LEN = 1,
   parameter int unsigned EDGE_MODE = 0,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   flex_enable_gen_if.slave bus
);
   localparam logic [3:0] PulseReload = 4'(PULSE_LEN - 1);

   typedef enum logic [1:0] {StArm, StIdle, StPulse} state_e;

`ifdef FLEX_ENABLE_CNT_EN
   localparam int unsigned SelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   logic [CNT_W-1:0] w_evt [NUM_CH];
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_e     r_state, w_state;
      logic       r_prev;
      logic [3:0] r_cnt, w_cnt;
      logic       r_ovr, w_ovr_set;
      logic       w_rise, w_fall, w_trig;

      assign w_rise = bus.slow_enable[g] & ~r_prev;
      assign w_fall = ~bus.slow_enable[g] & r_prev;
      assign w_trig = (EDGE_MODE == 0) ? w_rise :
                      (EDGE_MODE == 1) ? w_fall : (w_rise | w_fall);

      always_comb begin
         w_state   = r_state;
         w_cnt     = r_cnt;
         w_ovr_set = 1'b0;
         unique case (r_state)
            StArm: w_state = StIdle;
            StIdle: begin
               if (w_trig) begin
                  w_state = StPulse;
                  w_cnt   = PulseReload;
               end
            end
            StPulse: begin
               // A trigger on the final pulse cycle starts a fresh pulse back-to-back.
               if (r_cnt == 4'd0) begin
                  if (w_trig) begin
                     w_cnt = PulseReload;
                  end else begin
                     w_state = StIdle;
                  end
               end else begin
                  w_cnt     = r_cnt - 4'd1;
                  w_ovr_set = w_trig;
               end
            end
            default: w_state = StArm;
         endcase
      end

      always_ff @(posedge clk) begin
         if (n_rst) begin
            r_state <= StArm;
            r_prev  <= 1'b0;
            r_cnt   <= 4'd0;
            r_ovr   <= 1'b0;
         end else begin
            r_state <= w_state;
            r_prev  <= bus.slow_enable[g];
            r_cnt   <= w_cnt;
            r_ovr   <= w_ovr_set | (r_ovr & ~bus.ovr_clr[g]);
         end
      end

      assign bus.fast_enable[g] = (r_state == StPulse);
      assign bus.busy[g]        = (r_state == StPulse);
      assign bus.overrun[g]     = r_ovr;

`ifdef FLEX_ENABLE_CNT_EN
      logic             w_accept;
      logic [CNT_W-1:0] r_evt;

      assign w_accept = w_trig & ((r_state == StIdle) |
                                  ((r_state == StPulse) & (r_cnt == 4'd0)));

      always_ff @(posedge clk) begin
         if (n_rst) begin
            r_evt <= '0;
         end else if (w_accept && (r_evt != '1)) begin
            r_evt <= r_evt + 1'b1;
         end
      end

      assign w_evt[g] = r_evt;
`endif
   end

`ifdef FLEX_ENABLE_CNT_EN
   // Out-of-range selects match no channel and fall through to zero.
   always_comb begin
      bus.cnt_out = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (bus.cnt_sel == SelW'(i)) begin
            bus.cnt_out = w_evt[i];
         end
      end
   end
`else
   assign bus.cnt_out = '0;
`endif
endmodule

// File: tb/tb_flex_enable_gen.sv
// Bench for flex_enable_gen: three instances (PULSE_LEN/EDGE_MODE variants) driven from a
// vector table through a scoreboard queue, plus a hand sequence for the event counters.
module tb_flex_enable_gen;
   logic clk   = 1'b0;
   logic n_rst = 1'b1;
   always #5 clk = ~clk;

`ifdef FLEX_ENABLE_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   flex_enable_gen_if #(.NUM_CH(4), .CNT_W(2)) bus_a ();
   flex_enable_gen_if #(.NUM_CH(4), .CNT_W(8)) bus_b ();
   flex_enable_gen_if #(.NUM_CH(4), .CNT_W(8)) bus_c ();

   flex_enable_gen #(.NUM_CH(4), .PULSE_LEN(3), .EDGE_MODE(0), .CNT_W(2)) u_dut_a (
      .clk(clk), .n_rst(n_rst), .bus(bus_a.slave));
   flex_enable_gen #(.NUM_CH(4), .PULSE_LEN(1), .EDGE_MODE(2), .CNT_W(8)) u_dut_b (
      .clk(clk), .n_rst(n_rst), .bus(bus_b.slave));
   flex_enable_gen #(.NUM_CH(4), .PULSE_LEN(2), .EDGE_MODE(1), .CNT_W(8)) u_dut_c (
      .clk(clk), .n_rst(n_rst), .bus(bus_c.slave));

   typedef struct {
      int         dut;
      logic       rst;
      logic [3:0] se;
      logic [3:0] clr;
      logic [3:0] fe;
      logic [3:0] ovr;
   } vec_t;

   typedef struct {
      int         dut;
      int         row;
      logic [3:0] fe;
      logic [3:0] ovr;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(int d, logic r, logic [3:0] se, logic [3:0] clr,
                               logic [3:0] fe, logic [3:0] ovr);
      vec_t v;
      v.dut = d; v.rst = r; v.se = se; v.clr = clr; v.fe = fe; v.ovr = ovr;
      vecs.push_back(v);
   endfunction

   function automatic void check(string name, logic [7:0] act, logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   function automatic logic [3:0] get_fe(int d);
      case (d)
         0:       return bus_a.fast_enable;
         1:       return bus_b.fast_enable;
         default: return bus_c.fast_enable;
      endcase
   endfunction

   function automatic logic [3:0] get_busy(int d);
      case (d)
         0:       return bus_a.busy;
         1:       return bus_b.busy;
         default: return bus_c.busy;
      endcase
   endfunction

   function automatic logic [3:0] get_ovr(int d);
      case (d)
         0:       return bus_a.overrun;
         1:       return bus_b.overrun;
         default: return bus_c.overrun;
      endcase
   endfunction

   task automatic drive(vec_t v);
      n_rst = v.rst;
      case (v.dut)
         0:       begin bus_a.slow_enable = v.se; bus_a.ovr_clr = v.clr; end
         1:       begin bus_b.slow_enable = v.se; bus_b.ovr_clr = v.clr; end
         default: begin bus_c.slow_enable = v.se; bus_c.ovr_clr = v.clr; end
      endcase
   endtask

   task automatic step_a(logic [3:0] se, logic [3:0] clr);
      n_rst = 1'b0;
      bus_a.slow_enable = se;
      bus_a.ovr_clr     = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      bus_a.slow_enable = '0; bus_a.ovr_clr = '0; bus_a.cnt_sel = '0;
      bus_b.slow_enable = '0; bus_b.ovr_clr = '0; bus_b.cnt_sel = '0;
      bus_c.slow_enable = '0; bus_c.ovr_clr = '0; bus_c.cnt_sel = '0;

      // B: PULSE_LEN=1, both edges; toggling ch1 gives back-to-back pulses, no overrun
      add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1, 0, 4'h2, 4'h0, 4'h2, 4'h0);
      add(1, 0, 4'h0, 4'h0, 4'h2, 4'h0);
      add(1, 0, 4'h2, 4'h0, 4'h2, 4'h0);
      add(1, 0, 4'h0, 4'h0, 4'h2, 4'h0);
      add(1, 0, 4'h2, 4'h0, 4'h2, 4'h0);
      add(1, 0, 4'h0, 4'h0, 4'h2, 4'h0);
      add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      // B: level at reset release is captured, not a trigger; a later fall is
      add(1, 1, 4'h3, 4'h0, 4'h0, 4'h0);
      add(1, 1, 4'h3, 4'h0, 4'h0, 4'h0);
      add(1, 0, 4'h3, 4'h0, 4'h0, 4'h0);
      add(1, 0, 4'h3, 4'h0, 4'h0, 4'h0);
      add(1, 0, 4'h1, 4'h0, 4'h2, 4'h0);
      // C: PULSE_LEN=2, falling edge; all-ones held through reset, then released low
      add(2, 1, 4'hF, 4'h0, 4'h0, 4'h0);
      add(2, 1, 4'hF, 4'h0, 4'h0, 4'h0);
      add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0);
      add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0);
      add(2, 0, 4'h0, 4'h0, 4'hF, 4'h0);
      add(2, 0, 4'h0, 4'h0, 4'hF, 4'h0);
      add(2, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0);
      add(2, 0, 4'h0, 4'h0, 4'hF, 4'h0);
      // C: reset mid-pulse truncates; released level 0101 must not trigger
      add(2, 1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(2, 1, 4'h5, 4'h0, 4'h0, 4'h0);
      add(2, 0, 4'h5, 4'h0, 4'h0, 4'h0);
      add(2, 0, 4'h5, 4'h0, 4'h0, 4'h0);
      add(2, 0, 4'h0, 4'h0, 4'h5, 4'h0);
      add(2, 0, 4'h0, 4'h0, 4'h5, 4'h0);
      add(2, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      // A: PULSE_LEN=3, rising edge
      add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 0, 4'h4, 4'h0, 4'h4, 4'h0);
      add(0, 0, 4'h4, 4'h0, 4'h4, 4'h0);
      add(0, 0, 4'h4, 4'h0, 4'h4, 4'h0);
      add(0, 0, 4'h4, 4'h0, 4'h0, 4'h0);
      // A: retrigger on ch0 mid-pulse -> overrun, pulse length unchanged
      add(0, 0, 4'h5, 4'h0, 4'h1, 4'h0);
      add(0, 0, 4'h4, 4'h0, 4'h1, 4'h0);
      add(0, 0, 4'h5, 4'h0, 4'h1, 4'h1);
      add(0, 0, 4'h5, 4'h0, 4'h0, 4'h1);
      add(0, 0, 4'h5, 4'h0, 4'h0, 4'h1);
      add(0, 0, 4'h5, 4'h1, 4'h0, 4'h0);
      // A: set and clear in the same cycle leaves overrun set
      add(0, 0, 4'h4, 4'h0, 4'h0, 4'h0);
      add(0, 0, 4'h5, 4'h0, 4'h1, 4'h0);
      add(0, 0, 4'h4, 4'h0, 4'h1, 4'h0);
      add(0, 0, 4'h5, 4'h1, 4'h1, 4'h1);
      add(0, 0, 4'h4, 4'h0, 4'h0, 4'h1);
      add(0, 0, 4'h4, 4'h1, 4'h0, 4'h0);
      // A: simultaneous triggers on every channel
      add(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 0, 4'hF, 4'h0, 4'hF, 4'h0);
      add(0, 0, 4'hF, 4'h0, 4'hF, 4'h0);
      add(0, 0, 4'hF, 4'h0, 4'hF, 4'h0);
      add(0, 0, 4'hF, 4'h0, 4'h0, 4'h0);

      foreach (vecs[i]) begin
         exp_t x;
         drive(vecs[i]);
         x.dut = vecs[i].dut; x.row = i; x.fe = vecs[i].fe; x.ovr = vecs[i].ovr;
         sb_q.push_back(x);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         check($sformatf("row%0d_dut%0d_fast_enable", e.row, e.dut), 8'(get_fe(e.dut)),
               8'(e.fe));
         check($sformatf("row%0d_dut%0d_busy", e.row, e.dut), 8'(get_busy(e.dut)), 8'(e.fe));
         check($sformatf("row%0d_dut%0d_overrun", e.row, e.dut), 8'(get_ovr(e.dut)),
               8'(e.ovr));
      end

      // A counters so far: ch0=3 ch1=1 ch2=2 ch3=1. Four more spaced triggers on ch3.
      for (int k = 0; k < 4; k++) begin
         step_a(4'h7, 4'h0);
         step_a(4'hF, 4'h0);
         step_a(4'hF, 4'h0);
         step_a(4'hF, 4'h0);
      end
      // ch1: one accepted trigger, then one mid-pulse (overrun, not counted)
      step_a(4'hD, 4'h0);
      step_a(4'hF, 4'h0);
      step_a(4'hD, 4'h0);
      step_a(4'hF, 4'h0);
      check("cnt_ch1_overrun", 8'(bus_a.overrun), 8'h2);
      step_a(4'hF, 4'h0);
      step_a(4'hF, 4'h0);
      check("cnt_ch1_pulse_done", 8'(bus_a.fast_enable), 8'h0);

      bus_a.cnt_sel = 2'd3; #1;
      check("cnt_ch3_saturated", 8'(bus_a.cnt_out), CntEn ? 8'd3 : 8'd0);
      bus_a.cnt_sel = 2'd1; #1;
      check("cnt_ch1_no_overrun_count", 8'(bus_a.cnt_out), CntEn ? 8'd2 : 8'd0);
      bus_a.cnt_sel = 2'd2; #1;
      check("cnt_ch2", 8'(bus_a.cnt_out), CntEn ? 8'd2 : 8'd0);
      bus_a.cnt_sel = 2'd0; #1;
      check("cnt_ch0", 8'(bus_a.cnt_out), CntEn ? 8'd3 : 8'd0);

      n_rst = 1'b1;
      bus_a.cnt_sel = 2'd3;
      @(posedge clk);
      #1;
      check("reset_cnt_out", 8'(bus_a.cnt_out), 8'd0);
      check("reset_overrun", 8'(bus_a.overrun), 8'h0);
      check("reset_fast_enable", 8'(bus_a.fast_enable), 8'h0);
      check("cnt_b_unselected_zero", 8'(bus_b.cnt_out), CntEn ? 8'd0 : 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/flex_enable_gen.md
FLEX_ENABLE_GEN -- requirements
Module: flex_enable_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent enable channels (1..16).
REQ-002 Parameter PULSE_LEN, default 1, fast_enable pulse width in clk cycles (1..15).
REQ-003 Parameter EDGE_MODE, default 0, trigger edge: 0 rising, 1 falling, 2 both.
REQ-004 Parameter CNT_W, default 8, width of per-channel event counters.
REQ-005 Port clk  input  1  single system clock; all logic on rising edge.
REQ-006 Port n_rst  input  1  synchronous, active-high reset (1 = reset).
REQ-007 Port slow_enable  input  NUM_CH  per-channel slow level/strobe, clk-synchronous.
REQ-008 Port ovr_clr  input  NUM_CH  per-channel clear of the overrun flag.
REQ-009 Port cnt_sel  input  max(1,$clog2(NUM_CH))  channel select for cnt_out.
REQ-010 Port fast_enable  output  NUM_CH  per-channel registered pulse.
REQ-011 Port busy  output  NUM_CH  high while channel is in PULSE state.
REQ-012 Port overrun  output  NUM_CH  sticky flag: trigger edge arrived while busy.
REQ-013 Port cnt_out  output  CNT_W  event count of channel cnt_sel.

Function
REQ-014 Each channel SHALL run an independent FSM: ARM, IDLE, PULSE.
REQ-015 ARM: capture slow_enable[i] into prev[i], no event detection, go to IDLE next cycle.
REQ-016 IDLE: prev[i] updates every cycle; trigger = edge between prev[i] and slow_enable[i] per EDGE_MODE.
REQ-017 On trigger at clock edge k, fast_enable[i] SHALL be 1 from edge k for exactly PULSE_LEN cycles; FSM enters PULSE, down-counter loads PULSE_LEN-1.
REQ-018 PULSE: counter decrements each cycle; at 0 with no pending work, fast_enable[i] deasserts and FSM returns to IDLE.
REQ-019 Trigger during PULSE SHALL NOT extend or restart the pulse; overrun[i] SHALL set.
REQ-020 PULSE_LEN=1 with triggers on consecutive cycles (EDGE_MODE 2, toggling input): each trigger SHALL produce its own 1-cycle pulse (back-to-back), no overrun.
REQ-021 overrun[i] clears on ovr_clr[i]; simultaneous set and clear SHALL leave overrun[i]=1.
REQ-022 busy[i] SHALL equal (state==PULSE); fast_enable[i] SHALL equal busy[i].
REQ-023 Channels SHALL NOT interact; simultaneous triggers on all channels SHALL all be honoured.
REQ-024 cnt_sel >= NUM_CH SHALL give cnt_out=0.

Reset
REQ-025 n_rst=1 at a clock edge SHALL force every channel to ARM, fast_enable=0, busy=0, overrun=0, counters=0, prev=0.
REQ-026 Reset mid-pulse SHALL truncate the pulse at that edge; no trigger SHALL be raised by the level present at reset release.

Configuration
REQ-027 Macro FLEX_ENABLE_CNT_EN defined: each channel keeps a CNT_W-bit counter incremented per accepted trigger (not overrun triggers), saturating at 2^CNT_W-1; cnt_out is combinational mux of selected counter.
REQ-028 Macro undefined: no counters synthesised, cnt_out SHALL be constant 0; all other behaviour identical.

Verification
REQ-029 NUM_CH=4, PULSE_LEN=3, EDGE_MODE=0: slow_enable[2] 0->1 sampled at edge 10 -> fast_enable[2]=1 for edges 10..12, 0 at 13; other channels 0.
REQ-030 PULSE_LEN=3: second rising edge on ch0 two cycles after first -> pulse still ends after 3 cycles, overrun[0]=1 until ovr_clr[0] pulse; ovr_clr with new overrun same cycle -> overrun stays 1.
REQ-031 EDGE_MODE=2, PULSE_LEN=1: slow_enable[1] toggled every cycle for 6 cycles -> 6 consecutive fast_enable[1] cycles, overrun[1]=0.
REQ-032 slow_enable=4'hF held through reset release -> no fast_enable pulses; subsequent 1->0 with EDGE_MODE=1 -> one pulse per channel.
REQ-033 FLEX_ENABLE_CNT_EN, CNT_W=2: 5 accepted triggers on ch3, cnt_sel=3 -> cnt_out=3 (saturated); n_rst -> cnt_out=0; macro undefined -> cnt_out=0 throughout.
